// File: rtl/video_timing_pkg.sv
// video_timing_pkg: shared geometry type, default Solomon arcade timing and sync-start helper.
// Used by video_timing_gen and vtg_axis through import video_timing_pkg::*.
package video_timing_pkg;

    typedef struct packed {
        int active;
        int front;
        int sync;
        int back;
    } geom_t;

    localparam geom_t H_GEOM_DEF = '{active: 256, front: 16, sync: 32, back: 80};
    localparam geom_t V_GEOM_DEF = '{active: 224, front: 8, sync: 4, back: 28};
    localparam int H_OFS_STEP = 2;

    function automatic int geom_total(geom_t g);
        return g.active + g.front + g.sync + g.back;
    endfunction

    // Nominal sync start shifted by a signed offset, clamped so the pulse
    // always sits wholly inside the blanking interval.
    function automatic int sync_start(geom_t g, int ofs);
        int lo, hi, s;
        lo = g.active;
        hi = geom_total(g) - g.sync;
        s  = g.active + g.front + ofs;
        return s < lo ? lo : (s > hi ? hi : s);
    endfunction

endpackage

// File: rtl/vtg_axis.sv
// vtg_axis: one raster axis counter with registered blank and active-low sync.
// Ports: clk, rst_n (async active-low); ce gates all state; advance steps the count;
//        sync_start selects the sync window; count/blank/sync registered outputs;
//        wrap flags the terminal count; blank_nxt is the blank value the next ce loads.
module vtg_axis
    import video_timing_pkg::*;
#(
    parameter int    CNT_W = 9,
    parameter geom_t G     = H_GEOM_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ce,
    input  logic             advance,
    input  logic [CNT_W-1:0] sync_start,
    output logic [CNT_W-1:0] count,
    output logic             wrap,
    output logic             blank,
    output logic             blank_nxt,
    output logic             sync
);
    localparam int TOTAL = geom_total(G);

    logic [CNT_W-1:0] nxt;

    assign wrap      = count == CNT_W'(TOTAL - 1);
    assign nxt       = advance ? (wrap ? '0 : count + 1'b1) : count;
    assign blank_nxt = nxt >= CNT_W'(G.active);

    // Flags load from the next count so they line up with the count they describe.
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            count <= '0;
            blank <= 1'b1;
            sync  <= 1'b1;
        end else if (ce) begin
            count <= nxt;
            blank <= blank_nxt;
            sync  <= !(nxt >= sync_start && nxt < sync_start + CNT_W'(G.sync));
        end

endmodule

// File: rtl/video_timing_gen.sv
// video_timing_gen: parametrised raster timing generator for arcade cores.
// Ports: MCLK clock, RESET_N async active-low reset, CE_PIX pixel enable;
//        HOFFS/VOFFS signed sync offsets (latched at frame start); IRGB core colour;
//        HPOS fetch x (hcnt + H_LEAD), VPOS line; ORGB blank-gated colour;
//        HBLK/VBLK blanks, HSYN/VSYN active-low syncs, DE display enable;
//        FRAME_STB frame-start pulse; LINE_IRQ raster compare pulse.
// Optional: define VIDEO_TIMING_LINE_IRQ_EN to add IRQ_LINE/IRQ_ENA and drive LINE_IRQ;
//           otherwise LINE_IRQ is tied low.
module video_timing_gen
    import video_timing_pkg::*;
#(
    parameter int H_ACTIVE = H_GEOM_DEF.active,
    parameter int H_FRONT  = H_GEOM_DEF.front,
    parameter int H_SYNC   = H_GEOM_DEF.sync,
    parameter int H_BACK   = H_GEOM_DEF.back,
    parameter int V_ACTIVE = V_GEOM_DEF.active,
    parameter int V_FRONT  = V_GEOM_DEF.front,
    parameter int V_SYNC   = V_GEOM_DEF.sync,
    parameter int V_BACK   = V_GEOM_DEF.back,
    parameter int CNT_W    = 9,
    parameter int RGB_W    = 12,
    parameter int HOFS_W   = 5,
    parameter int VOFS_W   = 3,
    parameter int H_LEAD   = 16
) (
    input  logic                     MCLK,
    input  logic                     RESET_N,
    input  logic                     CE_PIX,
    input  logic signed [HOFS_W-1:0] HOFFS,
    input  logic signed [VOFS_W-1:0] VOFFS,
    input  logic        [RGB_W-1:0]  IRGB,
`ifdef VIDEO_TIMING_LINE_IRQ_EN
    input  logic        [CNT_W-1:0]  IRQ_LINE,
    input  logic                     IRQ_ENA,
`endif
    output logic        [CNT_W-1:0]  HPOS,
    output logic        [CNT_W-1:0]  VPOS,
    output logic        [RGB_W-1:0]  ORGB,
    output logic                     HBLK,
    output logic                     VBLK,
    output logic                     HSYN,
    output logic                     VSYN,
    output logic                     DE,
    output logic                     FRAME_STB,
    output logic                     LINE_IRQ
);
    localparam geom_t HG = '{active: H_ACTIVE, front: H_FRONT, sync: H_SYNC, back: H_BACK};
    localparam geom_t VG = '{active: V_ACTIVE, front: V_FRONT, sync: V_SYNC, back: V_BACK};

    logic [CNT_W-1:0] hcnt, hs_start, vs_start;
    logic h_wrap, v_wrap, h_blank_nxt, v_blank_nxt, frame_wrap;
    logic signed [HOFS_W-1:0] hofs;
    logic signed [VOFS_W-1:0] vofs;

    // Sync positions come only from the per-frame latched offsets.
    assign hs_start   = CNT_W'(sync_start(HG, int'(hofs) * H_OFS_STEP));
    assign vs_start   = CNT_W'(sync_start(VG, int'(vofs)));
    assign frame_wrap = CE_PIX & h_wrap & v_wrap;

    vtg_axis #(.CNT_W(CNT_W), .G(HG)) u_h (
        .clk(MCLK), .rst_n(RESET_N), .ce(CE_PIX), .advance(CE_PIX),
        .sync_start(hs_start), .count(hcnt), .wrap(h_wrap),
        .blank(HBLK), .blank_nxt(h_blank_nxt), .sync(HSYN)
    );

    vtg_axis #(.CNT_W(CNT_W), .G(VG)) u_v (
        .clk(MCLK), .rst_n(RESET_N), .ce(CE_PIX), .advance(CE_PIX & h_wrap),
        .sync_start(vs_start), .count(VPOS), .wrap(v_wrap),
        .blank(VBLK), .blank_nxt(v_blank_nxt), .sync(VSYN)
    );

    assign HPOS = hcnt + CNT_W'(H_LEAD);
    assign DE   = ~(HBLK | VBLK);

    always_ff @(posedge MCLK or negedge RESET_N)
        if (!RESET_N) begin
            hofs      <= '0;
            vofs      <= '0;
            ORGB      <= '0;
            FRAME_STB <= 1'b0;
        end else begin
            FRAME_STB <= frame_wrap;
            if (frame_wrap) begin
                hofs <= HOFFS;
                vofs <= VOFFS;
            end
            if (CE_PIX)
                ORGB <= (h_blank_nxt | v_blank_nxt) ? '0 : IRGB;
        end

`ifdef VIDEO_TIMING_LINE_IRQ_EN
    logic [CNT_W-1:0] v_nxt;

    // Out-of-range IRQ_LINE values never match a reachable line.
    assign v_nxt = v_wrap ? '0 : VPOS + 1'b1;

    always_ff @(posedge MCLK or negedge RESET_N)
        if (!RESET_N)
            LINE_IRQ <= 1'b0;
        else
            LINE_IRQ <= CE_PIX & h_wrap & IRQ_ENA & (v_nxt == IRQ_LINE);
`else
    assign LINE_IRQ = 1'b0;
`endif

endmodule
